// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a valid/ready request and valid response
// interface, holds the instruction register and counts retired instructions.
module instr_fetch_unit #(
    parameter int                XLEN          = 32,
    parameter logic [XLEN-1:0]   RESET_PC      = '0,
    parameter logic [31:0]       INSTRET_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      op_code,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            instr_ack,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            misaligned_err,
    output logic [31:0]     instret
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RSP,
        HOLD,
        ERROR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] next_pc;
    logic            retire;
    logic            target_bad;

    assign pc_plus4      = pc + XLEN'(4);
    assign next_pc       = pc_src ? pc_target : pc_plus4;
    assign retire        = (state == HOLD) && instr_ack;
    assign target_bad    = (next_pc[1:0] != 2'b00);
    assign imem_req_addr = pc;
    assign op_code       = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = FETCH;
            FETCH:    if (imem_req_ready) state_next = WAIT_RSP;
            WAIT_RSP: if (imem_rsp_valid) state_next = HOLD;
            HOLD:     if (instr_ack)      state_next = target_bad ? ERROR : FETCH;
            ERROR:    state_next = ERROR;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so they never combinationally follow inputs.
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state)
            FETCH:   imem_req_valid = 1'b1;
            HOLD:    instr_valid    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            instr          <= NOP;
            misaligned_err <= 1'b0;
            instret        <= INSTRET_RESET;
        end else begin
            if ((state == WAIT_RSP) && imem_rsp_valid) begin
                instr <= imem_rsp_data;
            end
            if (retire) begin
                instret <= instret + 32'd1;
                if (target_bad) begin
                    misaligned_err <= 1'b1;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and instructions are queued
// as stimulus is driven and compared when the DUT issues a request or presents an instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op_code;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ack = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        misaligned_err;
    logic [31:0] instret;

    logic        w_rst_n = 1'b0;
    logic        w_req_valid;
    logic        w_req_ready = 1'b1;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = 32'h0000_0033;
    logic        w_instr_valid;
    logic [31:0] w_instr;
    logic [6:0]  w_op_code;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_ack = 1'b0;
    logic        w_misaligned_err;
    logic [31:0] w_instret;

    int          total_checks = 0;
    int          passed_checks = 0;
    int          cyc = 0;
    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_instret;
    logic        model_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
        .op_code(op_code), .funct3(funct3), .funct7(funct7), .pc(pc), .pc_plus4(pc_plus4),
        .instr_ack(instr_ack), .pc_src(pc_src), .pc_target(pc_target),
        .misaligned_err(misaligned_err), .instret(instret)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .INSTRET_RESET(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .instr_valid(w_instr_valid), .instr(w_instr),
        .op_code(w_op_code), .funct3(w_funct3), .funct7(w_funct7), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .instr_ack(w_ack), .pc_src(1'b0), .pc_target(32'h0),
        .misaligned_err(w_misaligned_err), .instret(w_instret)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic resetModel();
        model_pc      = 32'h0;
        model_instret = 32'h0;
        model_err     = 1'b0;
        addr_q.delete();
        instr_q.delete();
        addr_q.push_back(32'h0);
    endtask

    // One full instruction: optional request backpressure, response delay and ack delay.
    task automatic applyStimulus(input int ready_wait, input bit junk, input int rsp_wait,
                                 input int ack_wait, input bit src, input logic [31:0] target,
                                 input logic [31:0] data, output int req_cycle);
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] nxt;
        int n;
        n = 0;
        req_cycle = -1;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req_valid) begin
            checkOutput("req_timeout", 32'(imem_req_valid), 32'h1);
            return;
        end
        req_cycle = cyc;
        exp_addr = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hXXXX_XXXX;
        checkOutput("req_addr", imem_req_addr, exp_addr);
        for (int i = 0; i < ready_wait; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = junk && (i == 0);
            imem_rsp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput("req_addr_stable", imem_req_addr, exp_addr);
            checkOutput("req_valid_stable", 32'(imem_req_valid), 32'h1);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        checkOutput("req_valid_drop", 32'(imem_req_valid), 32'h0);
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            checkOutput("instr_valid_wait", 32'(instr_valid), 32'h0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        instr_q.push_back(data);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hCAFE_F00D;
        exp_instr = instr_q.pop_front();
        checkOutput("instr_valid_hold", 32'(instr_valid), 32'h1);
        checkOutput("instr", instr, exp_instr);
        checkOutput("op_code", 32'(op_code), 32'(exp_instr[6:0]));
        checkOutput("funct3", 32'(funct3), 32'(exp_instr[14:12]));
        checkOutput("funct7", 32'(funct7), 32'(exp_instr[31:25]));
        for (int i = 0; i < ack_wait; i++) begin
            pc_src    = 1'b1;
            pc_target = 32'h0000_0100;
            @(negedge clk);
            checkOutput("hold_instr_stable", instr, exp_instr);
            checkOutput("hold_valid_stable", 32'(instr_valid), 32'h1);
        end
        instr_ack = 1'b1;
        pc_src    = src;
        pc_target = target;
        nxt = src ? target : model_pc + 32'd4;
        model_instret = model_instret + 32'd1;
        if (nxt[1:0] != 2'b00) begin
            model_err = 1'b1;
        end else begin
            model_pc = nxt;
            addr_q.push_back(nxt);
        end
        @(negedge clk);
        instr_ack = 1'b0;
        pc_src    = 1'b0;
        pc_target = 32'h0;
        checkOutput("instret", instret, model_instret);
        checkOutput("misaligned_err", 32'(misaligned_err), 32'(model_err));
        checkOutput("pc", pc, model_pc);
        checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pc"}, pc, 32'h0);
        checkOutput({tag, "_addr"}, imem_req_addr, 32'h0);
        checkOutput({tag, "_pc_plus4"}, pc_plus4, 32'h4);
        checkOutput({tag, "_ir"}, instr, 32'h0000_0013);
        checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
        checkOutput({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
        checkOutput({tag, "_err"}, 32'(misaligned_err), 32'h0);
        checkOutput({tag, "_instret"}, instret, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, c1, c2, c3;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        resetModel();
        rst_n = 1'b1;
        #1;
        checkOutput("idle_req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        checkOutput("first_req", 32'(imem_req_valid), 32'h1);

        applyStimulus(0, 0, 0, 0, 1'b0, 32'h0, 32'h0000_0013, c0);
        applyStimulus(0, 0, 0, 0, 1'b0, 32'h0, 32'h00A0_0093, c1);
        checkOutput("spacing_0_4", 32'(c1 - c0), 32'd3);
        applyStimulus(0, 0, 0, 0, 1'b1, 32'h0000_0010, 32'h0080_006F, c2);
        checkOutput("spacing_4_8", 32'(c2 - c1), 32'd3);
        applyStimulus(4, 1, 2, 2, 1'b0, 32'h0, 32'h4020_8133, c3);
        applyStimulus(0, 0, 0, 0, 1'b1, 32'h0000_0006, 32'h0000_8067, c3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("err_no_req", 32'(imem_req_valid), 32'h0);
            checkOutput("err_sticky", 32'(misaligned_err), 32'h1);
            checkOutput("err_pc", pc, 32'h0000_0014);
        end

        // Reset again, then assert reset in WAIT_RSP while a response arrives.
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("rst_err");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("restart_req", 32'(imem_req_valid), 32'h1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_wait");
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        checkOutput("rst_wait_ir", instr, 32'h0000_0013);
        resetModel();
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 0, 1, 0, 1'b0, 32'h0, 32'h0010_0113, c0);

        // Wrap instance: PC and instret roll over to zero.
        checkOutput("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_rst_pc_plus4", w_pc_plus4, 32'h0);
        checkOutput("wrap_rst_instret", w_instret, 32'hFFFF_FFFF);
        w_rst_n = 1'b1;
        @(negedge clk);
        checkOutput("wrap_req_valid", 32'(w_req_valid), 32'h1);
        checkOutput("wrap_req_addr", w_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        w_rsp_valid = 1'b1;
        @(negedge clk);
        w_rsp_valid = 1'b0;
        checkOutput("wrap_instr_valid", 32'(w_instr_valid), 32'h1);
        checkOutput("wrap_instr", w_instr, 32'h0000_0033);
        checkOutput("wrap_fields", {w_funct7, w_funct3, 15'h0, w_op_code}, 32'h0000_0033);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        checkOutput("wrap_instret", w_instret, 32'h0);
        checkOutput("wrap_next_addr", w_req_addr, 32'h0);
        checkOutput("wrap_next_req", 32'(w_req_valid), 32'h1);
        checkOutput("wrap_pc", w_pc, 32'h0);
        checkOutput("wrap_err", 32'(w_misaligned_err), 32'h0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
